// File: rtl/student_alu_pipe_if.sv
// student_alu_pipe_if: operand-side and result-side handshake bundle for
// student_alu_pipe. The ALU uses the slave modport; the producer/consumer
// side uses the master modport.
interface student_alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [5:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;

    modport master (
        output in_valid, x, y, ctrl, out_ready,
        input  in_ready, out_valid, out, zr, ng
    );

    modport slave (
        input  in_valid, x, y, ctrl, out_ready,
        output in_ready, out_valid, out, zr, ng
    );
endinterface

// File: rtl/student_alu_pipe.sv
// student_alu_pipe: two-stage pipelined Hack ALU with valid/ready handshakes.
// S1 pre-processes x/y with zx/nx/zy/ny; S2 applies f/no and derives zr/ng.
// Optional feature macro: STUDENT_ALU_SKID_EN adds a 1-entry skid register in
// front of S1 and makes in_ready a flop output (capacity 3 instead of 2).
module student_alu_pipe #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    student_alu_pipe_if.slave bus
);

    // S1 payload: pre-processed operands plus the function bits carried along.
    typedef struct packed {
        logic [WIDTH-1:0] xp;
        logic [WIDTH-1:0] yp;
        logic             f;
        logic             no;
    } s1_t;

    // Project-1 gate set, expressed as word-wide functions.
    function automatic logic [WIDTH-1:0] not16(input logic [WIDTH-1:0] a);
        return ~a;
    endfunction

    function automatic logic [WIDTH-1:0] and16(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        return a & b;
    endfunction

    function automatic logic [WIDTH-1:0] mux16(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sel);
        return sel ? b : a;
    endfunction

    // zero-then-negate operand pre-processing shared by x and y
    function automatic logic [WIDTH-1:0] preproc(input logic [WIDTH-1:0] v,
                                                 input logic             z,
                                                 input logic             n);
        logic [WIDTH-1:0] vz;
        vz = mux16(v, '0, z);
        return mux16(vz, not16(vz), n);
    endfunction

    // Pipeline state
    logic             s1_valid;
    s1_t              s1_q;
    logic             s2_valid;
    logic [WIDTH-1:0] out_q;
    logic             zr_q;
    logic             ng_q;

    // Handshake / advance terms
    logic             s2_load_ok;
    logic             s1_adv;
    logic             s1_load_ok;
    logic             accept;
    logic             in_ready_w;

    // Source feeding S1 (the input port, or the skid entry when present)
    logic             src_valid;
    logic [WIDTH-1:0] src_x;
    logic [WIDTH-1:0] src_y;
    logic [5:0]       src_ctrl;

    // A stage loads when empty or when its content leaves in the same cycle.
    assign s2_load_ok = !s2_valid || bus.out_ready;
    assign s1_adv     = s1_valid && s2_load_ok;
    assign s1_load_ok = !s1_valid || s1_adv;

`ifdef STUDENT_ALU_SKID_EN
    logic             skid_valid;
    logic             skid_valid_next;
    logic [WIDTH-1:0] skid_x;
    logic [WIDTH-1:0] skid_y;
    logic [5:0]       skid_ctrl;
    logic             in_ready_q;

    // in_ready is a flop: high only while the skid entry is free.
    assign in_ready_w = in_ready_q;
    assign accept     = bus.in_valid && in_ready_q;

    // The skid entry is older than anything on the port, so it feeds S1 first.
    assign src_valid = skid_valid || accept;
    assign src_x     = skid_valid ? skid_x    : bus.x;
    assign src_y     = skid_valid ? skid_y    : bus.y;
    assign src_ctrl  = skid_valid ? skid_ctrl : bus.ctrl;

    // A held entry stays until S1 can take it; a fresh beat parks here when S1 is blocked.
    assign skid_valid_next = skid_valid ? !s1_load_ok : (accept && !s1_load_ok);

    // Skid occupancy and registered in_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            skid_valid <= skid_valid_next;
            in_ready_q <= !skid_valid_next;
        end
    end

    // Skid payload capture; qualified by skid_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (accept && !s1_load_ok) begin
            skid_x    <= bus.x;
            skid_y    <= bus.y;
            skid_ctrl <= bus.ctrl;
        end
    end
`else
    logic init_done;

    // in_ready is combinational from out_ready through the S2/S1 advance chain.
    assign in_ready_w = init_done && s1_load_ok;
    assign accept     = bus.in_valid && in_ready_w;

    assign src_valid = accept;
    assign src_x     = bus.x;
    assign src_y     = bus.y;
    assign src_ctrl  = bus.ctrl;

    // Hold in_ready low through reset and release it one edge after rst_n rises
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end
`endif

    // Stage valid bits: bubbles propagate, a stage only changes when it may load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load_ok) begin
                s1_valid <= src_valid;
            end
            if (s2_load_ok) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // S1 datapath: zero/negate operands and carry f/no forward
    always_ff @(posedge clk) begin
        // NOTE: payload flops are qualified by s1_valid, so they are deliberately left unreset.
        if (s1_load_ok && src_valid) begin
            s1_q.xp <= preproc(src_x, src_ctrl[5], src_ctrl[4]);
            s1_q.yp <= preproc(src_y, src_ctrl[3], src_ctrl[2]);
            s1_q.f  <= src_ctrl[1];
            s1_q.no <= src_ctrl[0];
        end
    end

    // S2 function: add (carry dropped) or AND, then optional output negate
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] fn_r;
    logic [WIDTH-1:0] result;

    assign sum    = s1_q.xp + s1_q.yp;
    assign fn_r   = mux16(and16(s1_q.xp, s1_q.yp), sum, s1_q.f);
    assign result = mux16(fn_r, not16(fn_r), s1_q.no);

    // S2 result register; holds bit-stable until a new S1 beat advances into it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
        end else if (s1_adv) begin
            out_q <= result;
            zr_q  <= (result == '0);
            ng_q  <= result[WIDTH-1];
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = s2_valid;
    assign bus.out       = out_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;

endmodule
